// File: rtl/fd_circle_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : fd_circle_fetch
//  Description : Streaming front end for the FAST-9 corner datapath.
//                Buffers six image rows in line memories plus a 7x7 register
//                window. For every pixel whose radius-3 Bresenham circle lies
//                fully inside the image, presents the centre pixel and the
//                16 circle pixels (point 1 in the top byte of adjPixel).
//
//  Ports       : clk, rst_n            clock / async active-low reset
//                inPixel, inSof        raster-order pixel, start-of-frame
//                inValid / inReady     input handshake (inReady combinational)
//                refPixel              centre pixel of emitted window
//                adjPixel              circle points 1..16, point k at
//                                      bits [135-8k : 128-8k]
//                outValid / outReady   output handshake
//                outX, outY            centre coordinates (FD_COORD_EN only)
//
//  Options     : `define FD_COORD_EN adds the outX/outY coordinate outputs.
//
//  Revision    : 1.0  initial release
// ============================================================================
module fd_circle_fetch #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    inPixel,
  input  logic          inSof,
  input  logic          inValid,
  output logic          inReady,
  output logic [7:0]    refPixel,
  output logic [127:0]  adjPixel,
  output logic          outValid,
  input  logic          outReady
`ifdef FD_COORD_EN
  ,
  output logic [XW-1:0] outX,
  output logic [YW-1:0] outY
`endif
);

  localparam int c_LB_ROWS = 6;
  localparam int c_WIN     = 7;

  // --------------------------------------------------------------------------
  // Handshake and position of the pixel being accepted
  // --------------------------------------------------------------------------
  logic          r_valid;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic          w_acc;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_emit;

  assign inReady  = !r_valid || outReady;
  assign w_acc    = inValid && inReady;

  // A start-of-frame pixel is position (0,0) regardless of where the
  // counters were, so a partial frame is simply abandoned.
  assign w_px     = inSof ? '0 : r_x;
  assign w_py     = inSof ? '0 : r_y;

  assign w_x_last = (w_px == XW'(IMG_W - 1));
  assign w_y_last = (w_py == YW'(IMG_H - 1));

  // The window is complete once seven columns of this row and six rows
  // above it have been seen in the current frame.
  assign w_emit   = (w_px >= XW'(6)) && (w_py >= YW'(6));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_acc) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : (w_py + YW'(1));
      end else begin
        r_x <= w_px + XW'(1);
        r_y <= w_py;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Cascaded line buffers. Row k holds image row y-1-k. Each accept reads
  // column x of every row and shifts the old value one row down, so the
  // cascade behaves as read-before-write at a single address.
  // --------------------------------------------------------------------------
  logic [c_LB_ROWS-1:0][7:0] w_lbrd;

  for (genvar k = 0; k < c_LB_ROWS; k++) begin : g_lb
    logic [7:0] r_mem [IMG_W];
    logic [7:0] w_wr;

    if (k == 0) begin : g_first
      assign w_wr = inPixel;
    end else begin : g_casc
      assign w_wr = w_lbrd[k-1];
    end

    assign w_lbrd[k] = r_mem[w_px];

    always_ff @(posedge clk) begin
      if (w_acc) begin
        r_mem[w_px] <= w_wr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // 7x7 window. Row r holds image row y-6+r, column c holds image column
  // x-6+c; the centre therefore sits at [3][3].
  // --------------------------------------------------------------------------
  logic [7:0] r_win  [c_WIN][c_WIN];
  logic [7:0] w_nwin [c_WIN][c_WIN];
  logic [7:0] w_col  [c_WIN];

  always_comb begin
    for (int r = 0; r < c_WIN - 1; r++) begin
      w_col[r] = w_lbrd[c_LB_ROWS - 1 - r];
    end
    w_col[c_WIN-1] = inPixel;
  end

  // Window contents after this accept: shift left, new column on the right.
  always_comb begin
    for (int r = 0; r < c_WIN; r++) begin
      for (int c = 0; c < c_WIN - 1; c++) begin
        w_nwin[r][c] = r_win[r][c+1];
      end
      w_nwin[r][c_WIN-1] = w_col[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < c_WIN; r++) begin
        for (int c = 0; c < c_WIN; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_acc) begin
      for (int r = 0; r < c_WIN; r++) begin
        for (int c = 0; c < c_WIN; c++) begin
          r_win[r][c] <= w_nwin[r][c];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Circle taps, indexed [3+dy][3+dx], taken from the post-shift window so
  // the output register loads in the same cycle as the completing accept.
  // --------------------------------------------------------------------------
  logic [7:0]   w_ref;
  logic [127:0] w_adj;

  assign w_ref = w_nwin[3][3];
  assign w_adj = {
    w_nwin[0][3],  // 1  ( 0,-3)
    w_nwin[0][4],  // 2  ( 1,-3)
    w_nwin[1][5],  // 3  ( 2,-2)
    w_nwin[2][6],  // 4  ( 3,-1)
    w_nwin[3][6],  // 5  ( 3, 0)
    w_nwin[4][6],  // 6  ( 3, 1)
    w_nwin[5][5],  // 7  ( 2, 2)
    w_nwin[6][4],  // 8  ( 1, 3)
    w_nwin[6][3],  // 9  ( 0, 3)
    w_nwin[6][2],  // 10 (-1, 3)
    w_nwin[5][1],  // 11 (-2, 2)
    w_nwin[4][0],  // 12 (-3, 1)
    w_nwin[3][0],  // 13 (-3, 0)
    w_nwin[2][0],  // 14 (-3,-1)
    w_nwin[1][1],  // 15 (-2,-2)
    w_nwin[0][2]   // 16 (-1,-3)
  };

  // --------------------------------------------------------------------------
  // Output register. A load can only occur when inReady is high, so held
  // data is never overwritten while the consumer is stalling.
  // --------------------------------------------------------------------------
  logic [7:0]   r_ref;
  logic [127:0] r_adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ref   <= '0;
      r_adj   <= '0;
    end else if (w_acc && w_emit) begin
      r_valid <= 1'b1;
      r_ref   <= w_ref;
      r_adj   <= w_adj;
    end else if (outReady) begin
      r_valid <= 1'b0;
    end
  end

  assign outValid = r_valid;
  assign refPixel = r_ref;
  assign adjPixel = r_adj;

`ifdef FD_COORD_EN
  logic [XW-1:0] r_ox;
  logic [YW-1:0] r_oy;

  // Centre lies three columns left of and three rows above the newest pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ox <= '0;
      r_oy <= '0;
    end else if (w_acc && w_emit) begin
      r_ox <= w_px - XW'(3);
      r_oy <= w_py - YW'(3);
    end
  end

  assign outX = r_ox;
  assign outY = r_oy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fd_circle_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fd_circle_fetch
//  Description : Self-checking bench for fd_circle_fetch on an 8x8 image.
//                Expected outputs come from an image-level model: every
//                interior centre in raster order, circle points read from
//                the frame array by (dx,dy) offset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fd_circle_fetch;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int NP = W * H;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   inPixel;
  logic         inSof;
  logic         inValid;
  logic         inReady;
  logic [7:0]   refPixel;
  logic [127:0] adjPixel;
  logic         outValid;
  logic         outReady;
`ifdef FD_COORD_EN
  logic [XW-1:0] outX;
  logic [YW-1:0] outY;
`endif

  always #5 clk = ~clk;

  fd_circle_fetch #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inPixel  (inPixel),
    .inSof    (inSof),
    .inValid  (inValid),
    .inReady  (inReady),
    .refPixel (refPixel),
    .adjPixel (adjPixel),
    .outValid (outValid),
    .outReady (outReady)
`ifdef FD_COORD_EN
    ,
    .outX     (outX),
    .outY     (outY)
`endif
  );

  int checks   = 0;
  int failures = 0;

  int DX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  logic [7:0]   stim_pix [$];
  bit           stim_sof [$];
  logic [7:0]   exp_ref  [$];
  logic [127:0] exp_adj  [$];
  int           exp_x    [$];
  int           exp_y    [$];
  logic [7:0]   got_ref  [$];
  logic [127:0] got_adj  [$];
  int           got_x    [$];
  int           got_y    [$];
  int           hold_err;
  int           stall_err;

  logic [7:0] img_a [NP];
  logic [7:0] img_b [NP];

  task automatic clr();
    stim_pix.delete(); stim_sof.delete();
    exp_ref.delete();  exp_adj.delete(); exp_x.delete(); exp_y.delete();
  endtask

  // Queue the first npix pixels of a frame; a complete frame also queues
  // its expected outputs.
  task automatic add_frame(input logic [7:0] img [NP], input bit sof, input int npix);
    logic [127:0] a;
    for (int i = 0; i < npix; i++) begin
      stim_pix.push_back(img[i]);
      stim_sof.push_back(sof && (i == 0));
    end
    if (npix == NP) begin
      for (int cy = 3; cy <= H - 4; cy++) begin
        for (int cx = 3; cx <= W - 4; cx++) begin
          for (int k = 0; k < 16; k++) begin
            a[(15-k)*8 +: 8] = img[(cy + DY[k]) * W + cx + DX[k]];
          end
          exp_ref.push_back(img[cy * W + cx]);
          exp_adj.push_back(a);
          exp_x.push_back(cx);
          exp_y.push_back(cy);
        end
      end
    end
  endtask

  // Drives the queued stimulus and records every output handshake. When
  // hold_n > 0, outReady is held low for hold_n cycles once the first
  // output appears.
  task automatic run_stream(input int vpct, input int rpct, input int hold_n,
                            input int max_cyc, output int acc_first, output bit timeout);
    int idx = 0, acc = 0, cyc = 0, idle = 0, hold_left = 0;
    bit seen = 0, pv = 0, pr = 1;
    logic [7:0] pref = '0;
    logic [127:0] padj = '0;
    got_ref.delete(); got_adj.delete(); got_x.delete(); got_y.delete();
    hold_err = 0; stall_err = 0; acc_first = -1; timeout = 0;
    forever begin
      @(negedge clk);
      if (idx >= stim_pix.size()) begin
        if (!outValid) idle++;
        if (idle >= 3) break;
      end
      if (cyc >= max_cyc) begin timeout = 1; break; end
      if (outValid && !seen) begin
        seen = 1; acc_first = acc; hold_left = hold_n;
      end
      if (idx < stim_pix.size()) begin
        inValid = ($urandom_range(99) < vpct);
        inPixel = stim_pix[idx];
        inSof   = stim_sof[idx];
      end else begin
        inValid = 1'b0; inSof = 1'b0; inPixel = 8'($urandom);
      end
      if (hold_left > 0)                outReady = 1'b0;
      else if (idx >= stim_pix.size())  outReady = 1'b1;
      else                              outReady = ($urandom_range(99) < rpct);
      #1;
      if (pv && !pr && (outValid !== 1'b1 || refPixel !== pref || adjPixel !== padj)) hold_err++;
      if (hold_left > 0 && inReady !== 1'b0) stall_err++;
      if (outValid && outReady) begin
        got_ref.push_back(refPixel);
        got_adj.push_back(adjPixel);
`ifdef FD_COORD_EN
        got_x.push_back(int'(outX));
        got_y.push_back(int'(outY));
`endif
      end
      if (inValid && inReady) begin idx++; acc++; end
      if (hold_left > 0) hold_left--;
      pv = outValid; pr = outReady; pref = refPixel; padj = adjPixel;
      cyc++;
    end
    inValid = 1'b0; inSof = 1'b0; outReady = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (outValid !== 1'b0 || refPixel !== 8'd0 || adjPixel !== 128'd0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b ref=%0d adj=%h required 0/0/0", outValid, refPixel, adjPixel);
    end
    checks++;
    if (inReady !== 1'b1) begin
      failures++; $display("FAIL reset_inReady got=%b required 1", inReady);
    end
`ifdef FD_COORD_EN
    checks++;
    if (outX !== '0 || outY !== '0) begin
      failures++; $display("FAIL reset_coord got=(%0d,%0d) required (0,0)", outX, outY);
    end
`endif
  endtask

  task automatic test_ramp();
    int af; bit to;
    clr(); add_frame(img_a, 1'b1, NP);
    run_stream(100, 100, 0, 1000, af, to);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL ramp_timeout got=1 required 0"); end
    checks++;
    if (af != 55) begin failures++; $display("FAIL ramp_latency first valid after %0d accepts required 55", af); end
    checks++;
    if (got_ref.size() != 4) begin
      failures++; $display("FAIL ramp_count got=%0d required 4", got_ref.size());
    end else begin
      checks++;
      if (got_ref[0] !== 8'd27 || got_adj[0][127:120] !== 8'd3 || got_adj[0][95:88] !== 8'd30 ||
          got_adj[0][63:56] !== 8'd51 || got_adj[0][31:24] !== 8'd24) begin
        failures++;
        $display("FAIL ramp_first ref=%0d p1=%0d p5=%0d p9=%0d p13=%0d required 27/3/30/51/24",
                 got_ref[0], got_adj[0][127:120], got_adj[0][95:88], got_adj[0][63:56], got_adj[0][31:24]);
      end
      checks++;
      if (got_ref[3] !== 8'd36) begin failures++; $display("FAIL ramp_last ref=%0d required 36", got_ref[3]); end
    end
    for (int i = 0; i < exp_ref.size() && i < got_ref.size(); i++) begin
      checks++;
      if (got_ref[i] !== exp_ref[i] || got_adj[i] !== exp_adj[i]) begin
        failures++;
        $display("FAIL ramp_out[%0d] ref=%0d adj=%h required ref=%0d adj=%h", i, got_ref[i], got_adj[i], exp_ref[i], exp_adj[i]);
      end
`ifdef FD_COORD_EN
      checks++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        failures++;
        $display("FAIL ramp_coord[%0d] got=(%0d,%0d) required (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    int af; bit to;
    clr(); add_frame(img_a, 1'b1, NP);
    run_stream(100, 100, 5, 1000, af, to);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL bp_timeout got=1 required 0"); end
    checks++;
    if (stall_err != 0) begin failures++; $display("FAIL bp_inReady high in %0d stalled cycles required 0", stall_err); end
    checks++;
    if (hold_err != 0) begin failures++; $display("FAIL bp_hold outputs changed %0d times required 0", hold_err); end
    checks++;
    if (got_ref.size() != exp_ref.size()) begin
      failures++; $display("FAIL bp_count got=%0d required %0d", got_ref.size(), exp_ref.size());
    end
    for (int i = 0; i < exp_ref.size() && i < got_ref.size(); i++) begin
      checks++;
      if (got_ref[i] !== exp_ref[i] || got_adj[i] !== exp_adj[i]) begin
        failures++;
        $display("FAIL bp_out[%0d] ref=%0d adj=%h required ref=%0d adj=%h", i, got_ref[i], got_adj[i], exp_ref[i], exp_adj[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int af; bit to;
    clr(); add_frame(img_a, 1'b1, NP); add_frame(img_b, 1'b1, NP);
    run_stream(100, 100, 0, 1000, af, to);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL b2b_timeout got=1 required 0"); end
    checks++;
    if (got_ref.size() != 8) begin
      failures++; $display("FAIL b2b_count got=%0d required 8", got_ref.size());
    end else begin
      checks++;
      if (got_ref[4] !== 8'd228) begin failures++; $display("FAIL b2b_second_first ref=%0d required 228", got_ref[4]); end
    end
    for (int i = 0; i < exp_ref.size() && i < got_ref.size(); i++) begin
      checks++;
      if (got_ref[i] !== exp_ref[i] || got_adj[i] !== exp_adj[i]) begin
        failures++;
        $display("FAIL b2b_out[%0d] ref=%0d adj=%h required ref=%0d adj=%h", i, got_ref[i], got_adj[i], exp_ref[i], exp_adj[i]);
      end
    end
  endtask

  // Frame 1 is abandoned at position (5,4) by a new start of frame.
  task automatic test_sof_restart();
    int af; bit to;
    clr(); add_frame(img_b, 1'b1, 4 * W + 5); add_frame(img_a, 1'b1, NP);
    run_stream(100, 100, 0, 1000, af, to);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL sof_timeout got=1 required 0"); end
    checks++;
    if (af != 4 * W + 5 + 55) begin
      failures++; $display("FAIL sof_latency first valid after %0d accepts required %0d", af, 4 * W + 5 + 55);
    end
    checks++;
    if (got_ref.size() != exp_ref.size()) begin
      failures++; $display("FAIL sof_count got=%0d required %0d", got_ref.size(), exp_ref.size());
    end
    for (int i = 0; i < exp_ref.size() && i < got_ref.size(); i++) begin
      checks++;
      if (got_ref[i] !== exp_ref[i] || got_adj[i] !== exp_adj[i]) begin
        failures++;
        $display("FAIL sof_out[%0d] ref=%0d adj=%h required ref=%0d adj=%h", i, got_ref[i], got_adj[i], exp_ref[i], exp_adj[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int af; bit to; bit seen = 0; int i = 0;
    outReady = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (outValid) begin seen = 1; break; end
      inValid = 1'b1; inPixel = img_a[i % NP]; inSof = (i == 0); i++;
    end
    inValid = 1'b0; inSof = 1'b0;
    checks++;
    if (seen !== 1'b1) begin failures++; $display("FAIL rst_setup outValid never rose required 1"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || refPixel !== 8'd0) begin
      failures++;
      $display("FAIL rst_async valid=%b inReady=%b ref=%0d required 0/1/0", outValid, inReady, refPixel);
    end
    @(negedge clk); rst_n = 1'b1; outReady = 1'b1;
    // No start-of-frame marker: reset alone must restart at (0,0).
    clr(); add_frame(img_a, 1'b0, NP);
    run_stream(100, 100, 0, 1000, af, to);
    checks++;
    if (to !== 1'b0 || af != 55) begin
      failures++; $display("FAIL rst_restart timeout=%b first valid after %0d accepts required 0/55", to, af);
    end
    checks++;
    if (got_ref.size() != exp_ref.size()) begin
      failures++; $display("FAIL rst_count got=%0d required %0d", got_ref.size(), exp_ref.size());
    end
    for (int k = 0; k < exp_ref.size() && k < got_ref.size(); k++) begin
      checks++;
      if (got_ref[k] !== exp_ref[k] || got_adj[k] !== exp_adj[k]) begin
        failures++;
        $display("FAIL rst_out[%0d] ref=%0d adj=%h required ref=%0d adj=%h", k, got_ref[k], got_adj[k], exp_ref[k], exp_adj[k]);
      end
    end
  endtask

  // Random images and random handshakes; frames 2 and 3 rely on counter
  // wrap rather than a start-of-frame marker.
  task automatic test_random();
    int af; bit to;
    logic [7:0] img [NP];
    clr();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NP; i++) img[i] = 8'($urandom);
      add_frame(img, f == 0, NP);
    end
    run_stream(70, 60, 0, 5000, af, to);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL rand_timeout got=1 required 0"); end
    checks++;
    if (hold_err != 0) begin failures++; $display("FAIL rand_hold outputs changed %0d times required 0", hold_err); end
    checks++;
    if (got_ref.size() != exp_ref.size()) begin
      failures++; $display("FAIL rand_count got=%0d required %0d", got_ref.size(), exp_ref.size());
    end
    for (int i = 0; i < exp_ref.size() && i < got_ref.size(); i++) begin
      checks++;
      if (got_ref[i] !== exp_ref[i] || got_adj[i] !== exp_adj[i]) begin
        failures++;
        $display("FAIL rand_out[%0d] ref=%0d adj=%h required ref=%0d adj=%h", i, got_ref[i], got_adj[i], exp_ref[i], exp_adj[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      img_a[i] = 8'(i);
      img_b[i] = 8'(255 - i);
    end
    rst_n = 1'b0; inValid = 1'b0; inSof = 1'b0; inPixel = 8'd0; outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_ramp();
    test_backpressure();
    test_back_to_back();
    test_sof_restart();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fd_circle_fetch.md
# fd_circle_fetch

Streaming front end for the FAST-9 corner datapath. Accepts a raster-order 8-bit grayscale pixel stream and buffers six image rows plus a 7×7 register window. For every pixel whose radius-3 Bresenham circle lies fully inside the image, it presents the centre pixel and the 16 circle pixels, packed in the order the corner datapath consumes. It sits between the camera/DMA pixel source and the combinational corner test, with a valid/ready handshake on both sides.

## Interface
- IMG_W, 640, image width in pixels (≥ 7)
- IMG_H, 480, image height in rows (≥ 7)
- XW, 10, column counter width (2^XW ≥ IMG_W)
- YW, 9, row counter width (2^YW ≥ IMG_H)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- inPixel  in  8  raster-order input pixel
- inSof  in  1  start of frame, qualifies the pixel carrying it
- inValid  in  1  inPixel/inSof valid
- inReady  out  1  block accepts the input pixel this cycle
- refPixel  out  8  centre pixel of the emitted window
- adjPixel  out  128  circle points 1..16; point k at bits [135-8k : 128-8k]
- outValid  out  1  refPixel/adjPixel valid
- outReady  in  1  consumer accepts the output
- outX  out  XW  centre column (FD_COORD_EN only)
- outY  out  YW  centre row (FD_COORD_EN only)

## Operation
- Accept: a pixel is taken when inValid && inReady. inReady = !outValid || outReady.
- Position counters x, y give the position of the accepted pixel.
  - x increments per accept. At IMG_W-1 it wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1) both wrap to 0.
  - An accepted pixel with inSof=1 is treated as position (0,0), whatever the counter values. Counters continue from there.
- Line buffers: 6 rows × IMG_W × 8 bits, cascaded. Column x of rows y-1..y-6 is read and column x of row y is written on the same accept, with read-before-write.
- Window: 7 columns × 7 rows of registers, shifted left one column per accept. The new column is {line buffers rows y-6..y-1, inPixel}.
- Emit condition: the accepted pixel has x ≥ 6 and y ≥ 6. The emitted centre is (x-3, y-3).
- Circle point offsets (dx,dy) from the centre, with dy positive downward, points 1..16:
  - (0,-3) (1,-3) (2,-2) (3,-1)
  - (3,0) (3,1) (2,2) (1,3)
  - (0,3) (-1,3) (-2,2) (-3,1)
  - (-3,0) (-3,-1) (-2,-2) (-1,-3)
- Border pixels (centre within 3 of any edge) are never emitted. Per frame, (IMG_W-6)·(IMG_H-6) outputs.
- Line buffer contents from a previous frame are never emitted, since the emit condition requires y ≥ 6 of the current frame.
- No arithmetic beyond counter increment and compare. Pixels pass through unmodified.

## Timing
- Reset values:
  - outValid=0; refPixel=0; adjPixel=0
  - outX=0; outY=0
  - x=0; y=0
  - window registers 0; line buffer contents don't-care
- inReady is combinational from outValid/outReady and is 1 out of reset.
- Latency: the accept that completes a window in cycle N gives outValid=1 with that window in cycle N+1.
- Output register:
  - Loads on any accept that meets the emit condition.
  - Clears outValid on outReady when no new emit is loading.
  - Holds all output values stable while outValid && !outReady.
- Stall: while inReady=0, no counter, window or line buffer state changes.
- Full throughput: one pixel per cycle with outReady held high.
- Simultaneous outReady and a new emitting accept in the same cycle: the new data replaces the old, and outValid stays 1.
- inSof mid-frame: the current partial frame is abandoned. No outputs are emitted until the new frame reaches y ≥ 6.
- rst_n low mid-frame: clears immediately. The next accepted pixel is (0,0).

## Configuration
- FD_COORD_EN defined: ports outX/outY exist. They are registered alongside refPixel with the centre coordinates (x-3, y-3).
- FD_COORD_EN undefined: outX/outY ports and their registers are absent. The rest of the behaviour is identical.

## Test plan
- Ramp image, IMG_W=IMG_H=8, pixel=8y+x, outReady=1. Required response:
  - first outValid one cycle after the 55th accept
  - refPixel=27
  - points 1/5/9/13 = 3/30/51/24
  - exactly 4 outputs per frame, last refPixel=36
- Backpressure: hold outReady=0 for 5 cycles after the first output. Required response: inReady=0, outputs unchanged, no pixel lost; the output sequence matches the no-stall run.
- Back-to-back frames with inSof on each first pixel, second frame pixel=255-(8y+x). Required response:
  - second-frame first refPixel=228
  - no output mixes first-frame data
- inSof asserted at frame-1 position (5,4). Required response: counters restart; the next output is centre (3,3) of the new frame, 55 accepts after that inSof.
- rst_n pulsed low mid-output while outValid=1. Required response: outValid=0 and inReady=1 immediately; after release, the ramp frame restarts and reproduces the first-test results.
- FD_COORD_EN build, ramp image. Required response: outX/outY sequence (3,3),(4,3),(3,4),(4,4).
